// File: rtl/ksa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ksa : ARC4 key-scheduling stage, permutes the 256x8 S memory in place |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ksa (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  addr,
   input  logic [7:0]  rddata,
   output logic [7:0]  wrdata,
   output logic        wren
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_I  = 3'd1,
      S_CALC  = 3'd2,
      S_RD_J  = 3'd3,
      S_CAP_J = 3'd4,
      S_WR_I  = 3'd5,
      S_WR_J  = 3'd6
   } state_t;

   state_t      r_state;
   logic [7:0]  r_i;
   logic [7:0]  r_j;
   logic [1:0]  r_ksel;
   logic [23:0] r_key;
   logic [7:0]  r_si;
   logic [7:0]  w_kbyte;
   logic [7:0]  w_j_next;

   always_comb begin
      w_kbyte = r_key[7:0];
      case (r_ksel)
         2'd0:    w_kbyte = r_key[23:16];
         2'd1:    w_kbyte = r_key[15:8];
         default: w_kbyte = r_key[7:0];
      endcase
      w_j_next = r_j + rddata + w_kbyte;
   end

   // Outputs are registered one state ahead so addr/wren are valid for the
   // whole cycle of the state that owns them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         rdy     <= 1'b1;
         wren    <= 1'b0;
         addr    <= 8'd0;
         wrdata  <= 8'd0;
         r_i     <= 8'd0;
         r_j     <= 8'd0;
         r_ksel  <= 2'd0;
         r_key   <= 24'd0;
         r_si    <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               wren <= 1'b0;
               if (en) begin
                  r_key   <= key;
                  r_i     <= 8'd0;
                  r_j     <= 8'd0;
                  r_ksel  <= 2'd0;
                  addr    <= 8'd0;
                  rdy     <= 1'b0;
                  r_state <= S_RD_I;
               end
            end
            S_RD_I: r_state <= S_CALC;
            S_CALC: begin
               r_si    <= rddata;
               r_j     <= w_j_next;
               addr    <= w_j_next;
               r_state <= S_RD_J;
            end
            S_RD_J: r_state <= S_CAP_J;
            S_CAP_J: begin
               // wrdata doubles as the latched S[j]
               wrdata  <= rddata;
               addr    <= r_i;
               wren    <= 1'b1;
               r_state <= S_WR_I;
            end
            S_WR_I: begin
               addr    <= r_j;
               wrdata  <= r_si;
               r_state <= S_WR_J;
            end
            S_WR_J: begin
               wren <= 1'b0;
               if (r_i == 8'hFF) begin
                  rdy     <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_i     <= r_i + 8'd1;
                  addr    <= r_i + 8'd1;
                  r_ksel  <= (r_ksel == 2'd2) ? 2'd0 : r_ksel + 2'd1;
                  r_state <= S_RD_I;
               end
            end
            default: begin
               wren    <= 1'b0;
               rdy     <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ksa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ksa : directed bench for ksa with a behavioural S memory and model |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_ksa;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  addr;
   logic [7:0]  rddata;
   logic [7:0]  wrdata;
   logic        wren;

   logic [7:0]  mem [256];
   logic [7:0]  exp_s [256];
   logic [7:0]  raddr_q;
   logic        preload;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int wr_total = 0;
   int wr_base = 0;
   int last_wr_cyc = 0;
   int idle_wr = 0;
   logic [7:0] log_a [8];
   logic [7:0] log_d [8];

   ksa dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .rdy    (rdy),
      .key    (key),
      .addr   (addr),
      .rddata (rddata),
      .wrdata (wrdata),
      .wren   (wren)
   );

   always #5 clk = ~clk;

   // S memory: registered address, unregistered read data
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      raddr_q <= addr;
      if (preload) begin
         for (int k = 0; k < 256; k++) mem[k] <= k[7:0];
      end else if (wren) begin
         mem[addr] <= wrdata;
      end
   end
   assign rddata = mem[raddr_q];

   always @(negedge clk) begin
      if (wren) begin
         if (wr_total - wr_base < 8) begin
            log_a[wr_total - wr_base] <= addr;
            log_d[wr_total - wr_base] <= wrdata;
         end
         wr_total    <= wr_total + 1;
         last_wr_cyc <= cyc;
         if (rdy) idle_wr <= idle_wr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model(input logic [23:0] k);
      logic [7:0] j;
      logic [7:0] t;
      logic [7:0] kb [3];
      kb[0] = k[23:16];
      kb[1] = k[15:8];
      kb[2] = k[7:0];
      for (int i = 0; i < 256; i++) exp_s[i] = i[7:0];
      j = 8'd0;
      for (int i = 0; i < 256; i++) begin
         j = j + exp_s[i] + kb[i % 3];
         t = exp_s[i];
         exp_s[i] = exp_s[j];
         exp_s[j] = t;
      end
   endtask

   task automatic check_s(input string tag, input logic [23:0] k);
      int bad;
      model(k);
      bad = -1;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== exp_s[i] && bad < 0) bad = i;
      if (bad >= 0)
         $display("  %s first differing byte S[%0d]: observed %0h expected %0h",
                  tag, bad, mem[bad], exp_s[bad]);
      chk(tag, bad, -1);
   endtask

   task automatic do_preload();
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
   endtask

   // Called at a negedge with rdy=1; returns one negedge later.
   task automatic start(input logic [23:0] k, input logic pl);
      wr_base = wr_total;
      key     = k;
      en      = 1'b1;
      preload = pl;
      @(negedge clk);
      en      = 1'b0;
      preload = 1'b0;
   endtask

   // Counts negedges with rdy low; optionally pulses en with a corrupted key.
   task automatic wait_done(input logic pulse, input logic [23:0] k, output int n);
      n = 0;
      while (rdy !== 1'b1 && n < 3000) begin
         n++;
         if (pulse) begin
            en  = (n % 97 == 5);
            key = ~k;
         end
         @(negedge clk);
      end
      en  = 1'b0;
      key = k;
   endtask

   int n;

   initial begin
      rst = 1'b1; en = 1'b0; key = 24'd0; preload = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_rdy",    rdy,    1);
      chk("reset_wren",   wren,   0);
      chk("reset_addr",   addr,   0);
      chk("reset_wrdata", wrdata, 0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("idle_wren_pre", wren, 0);
      end

      // Run 1: all-zero key
      do_preload();
      start(24'h000000, 1'b0);
      wait_done(1'b0, 24'h000000, n);
      chk("k0_run_len", n, 1536);
      chk("k0_rdy_after_last_wr", cyc, last_wr_cyc + 1);
      chk("k0_write_count", wr_total - wr_base, 512);
      chk("k0_w0", {log_a[0], log_d[0]}, 16'h0000);
      chk("k0_w1", {log_a[1], log_d[1]}, 16'h0000);
      chk("k0_w2", {log_a[2], log_d[2]}, 16'h0101);
      chk("k0_w3", {log_a[3], log_d[3]}, 16'h0101);
      chk("k0_w4", {log_a[4], log_d[4]}, 16'h0203);
      chk("k0_w5", {log_a[5], log_d[5]}, 16'h0302);
      chk("k0_w6", {log_a[6], log_d[6]}, 16'h0305);
      chk("k0_w7", {log_a[7], log_d[7]}, 16'h0502);
      check_s("k0_final_s", 24'h000000);

      // Run 2: key 00033C
      do_preload();
      start(24'h00033C, 1'b0);
      chk("k33c_rdy_low_after_start", rdy, 0);
      wait_done(1'b0, 24'h00033C, n);
      chk("k33c_run_len", n, 1536);
      chk("k33c_rdy_after_last_wr", cyc, last_wr_cyc + 1);
      check_s("k33c_final_s", 24'h00033C);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle_wren_post", wren, 0);
      end

      // Run 3: en pulsed mid-run with a changed key
      do_preload();
      start(24'hA5F00D, 1'b0);
      wait_done(1'b1, 24'hA5F00D, n);
      chk("pulse_run_len", n, 1536);
      chk("pulse_write_count", wr_total - wr_base, 512);
      check_s("pulse_final_s", 24'hA5F00D);

      // Run 4: reset during WR_I of iteration 100
      do_preload();
      start(24'h5A5A5A, 1'b0);
      repeat (604) @(negedge clk);
      chk("rst_in_wr_i_wren", wren, 1);
      chk("rst_in_wr_i_addr", addr, 100);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_wren", wren, 0);
      chk("rst_async_rdy",  rdy,  1);
      @(negedge clk);
      chk("rst_held_rdy", rdy, 1);
      rst = 1'b0;
      do_preload();
      start(24'h5A5A5A, 1'b0);
      wait_done(1'b0, 24'h5A5A5A, n);
      chk("rst_rerun_len", n, 1536);
      check_s("rst_rerun_final_s", 24'h5A5A5A);

      // Runs 5/6: back-to-back start in the cycle rdy rises
      do_preload();
      start(24'h123456, 1'b0);
      wait_done(1'b0, 24'h123456, n);
      chk("b2b_first_len", n, 1536);
      check_s("b2b_first_final_s", 24'h123456);
      start(24'hFFFFFF, 1'b1);
      chk("b2b_no_gap_rdy", rdy, 0);
      wait_done(1'b0, 24'hFFFFFF, n);
      chk("b2b_second_len", n, 1536);
      check_s("b2b_second_final_s", 24'hFFFFFF);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle_wren_end", wren, 0);
      end
      chk("writes_while_idle", idle_wr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
